spi_trng_master: RTL and testbench
==================================

Name: spi_trng_master

Overview:
- SPI transmit master that serialises one DATA_WIDTH-bit TRNG word per transaction onto mosi/sclk/ss_n.
- Sits directly upstream of the TRNG SPI slave receiver. It also produces that receiver's start and tx_finish pulses.
- SPI mode 0, LSB first. The receiver samples on the sclk rising edge; this block changes mosi only while sclk is low.
- Upstream side is a valid/ready word interface from the TRNG entropy source.

Parameters:
- DATA_WIDTH, 96: bits per transaction; must equal the receiver's width.
- CLK_DIV, 4: sclk half-period in clk cycles; legal range ≥2, because the receiver detects sclk edges with clk.
- BIT_CNT_W, 7: width of bit counter; must satisfy 2^BIT_CNT_W > DATA_WIDTH.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  high only in IDLE; a word is accepted when tx_valid && tx_ready at a clk edge
- tx_data  in  DATA_WIDTH  word to send; bit 0 is sent first
- start  out  1  one-cycle pulse to receiver, precedes ss_n falling
- ss_n  out  1  active-low slave select
- sclk  out  1  serial clock, idle low
- mosi  out  1  serial data
- tx_finish  out  1  one-cycle pulse after ss_n deasserts
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous, active-low, on clk.
  - Reset values: state=IDLE, tx_ready=1, start=0, ss_n=1, sclk=0, mosi=0, tx_finish=0, busy=0, counters=0, shift register=0.
  - Reset mid-transfer aborts at once: ss_n=1 and sclk=0 asynchronously. No tx_finish is generated. The receiver is left to its own reset.
- All serial outputs (start, ss_n, sclk, mosi, tx_finish) are registered. tx_ready and busy decode state.
- State machine, one-hot, with D = CLK_DIV:
  - IDLE: on accept, latch tx_data into the shift register. Go to START.
  - START, 1 cycle: start=1, ss_n=1. Go to SETUP.
  - SETUP, D cycles: ss_n=0, sclk=0, mosi=shift[0]. Go to SCLK_HI.
  - SCLK_HI, D cycles: sclk=1, mosi held; bit_cnt increments on entry.
    - If bit_cnt==DATA_WIDTH at exit, go to HOLD.
    - Otherwise go to SCLK_LO.
  - SCLK_LO, D cycles: sclk=0. On entry the shift register shifts right by 1 and mosi takes the new shift[0]. Go to SCLK_HI.
  - HOLD, D cycles: sclk=0, ss_n=0, mosi held. Go to DONE.
  - DONE, 1 cycle: ss_n=1, tx_finish=1. Go to IDLE.
- Exactly DATA_WIDTH sclk rising edges occur per transaction, and no trailing falling-edge data change happens after the last bit.
- Timing, DATA_WIDTH=96, D=4, accept at edge T0:
  - start high T1; ss_n low T2..T773.
  - First sclk rise at T6; rises every 2D cycles; last rise at T766.
  - tx_finish at T774; tx_ready=1 at T775.
  - General latency, accept to tx_finish: 2 + D·(2·DATA_WIDTH + 1) cycles.
- tx_data is sampled only at accept. tx_valid outside IDLE is ignored and does not corrupt the latched word.
- Back-to-back: with tx_valid held high, the next accept occurs in the first IDLE cycle. ss_n is then high for at least 3 cycles (DONE, IDLE, START).
- Divider counter: counts 0..D-1, reloads on every state entry, and is never free-running.
- bit_cnt clears in IDLE and has no wrap-around, because the transition is taken at bit_cnt==DATA_WIDTH.

Decomposition:
- Shared package spi_trng_pkg holds:
  - state encoding localparams (IDLE, START, SETUP, SCLK_HI, SCLK_LO, HOLD, DONE, one-hot);
  - the default DATA_WIDTH=96, also used by the receiver;
  - the BIT_CNT_W derivation.
- One sub-module is natural: spi_sclk_gen. It holds the CLK_DIV phase counter, which reloads on a restart input and outputs a phase_done tick consumed by the FSM. The rest lives in the top.

Test Plan:
- Reset: assert rst_n low mid-cycle → ss_n=1, sclk=0, mosi=0, start=0, tx_finish=0, tx_ready=1 immediately, before any clk edge.
- Single word 96'h0123_4567_89AB_CDEF_FEDC_BA98, D=4, receiver model attached:
  - exactly 96 sclk rises; receiver data_o equals the word at its r_finish;
  - start at T1, first rise T6, last rise T766, tx_finish at T774.
- Back-to-back: tx_valid held high with words 96'hAAAA…AA then 96'h5555…55 → second accepted at T775; ss_n high during T774..T776; both words received intact.
- tx_valid toggled with 96'hFFFF…FF during a transfer of 96'h0 → mosi stays 0 on all 96 rising edges; tx_ready stays 0 until IDLE.
- Reset asserted after the 40th sclk rise, released, then word 96'h1 sent → no tx_finish from the aborted transfer; the new transfer yields mosi=1 only on the first rise.
- CLK_DIV=2 sweep with random words → mosi changes only while sclk=0 and is stable ≥2 clk before every rise; latency = 2 + 2·(2·96+1) = 388 cycles.

Source files
------------

// File: rtl/spi_trng_pkg.sv
// Shared definitions for the TRNG SPI link: state encoding, default word width
// and the bit-counter width derivation used by both master and receiver.
package spi_trng_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 96;

    typedef enum logic [6:0] {
        IDLE    = 7'b0000001,
        START   = 7'b0000010,
        SETUP   = 7'b0000100,
        SCLK_HI = 7'b0001000,
        SCLK_LO = 7'b0010000,
        HOLD    = 7'b0100000,
        DONE    = 7'b1000000
    } state_e;

    // Counter must reach DATA_WIDTH itself, hence dw+1 values.
    function automatic int unsigned bit_cnt_width(input int unsigned dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/spi_trng_master_if.sv
// Word-in / SPI-out bundle of the TRNG SPI master; master modport is the DUT side.
interface spi_trng_master_if
    import spi_trng_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  start;
    logic                  ss_n;
    logic                  sclk;
    logic                  mosi;
    logic                  tx_finish;
    logic                  busy;

    modport master (
        input  tx_valid, tx_data,
        output tx_ready, start, ss_n, sclk, mosi, tx_finish, busy
    );

    modport slave (
        output tx_valid, tx_data,
        input  tx_ready, start, ss_n, sclk, mosi, tx_finish, busy
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// CLK_DIV phase counter: restarts on every FSM state entry and ticks phase_done
// in the last cycle of each phase; holds while disabled.
module spi_sclk_gen
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic restart_i,
    output logic phase_done_o
);
    localparam int unsigned      CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign phase_done_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/spi_trng_master.sv
// SPI mode-0, LSB-first transmit master for one TRNG word per transaction,
// also generating the receiver's start and tx_finish pulses.
module spi_trng_master
    import spi_trng_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned BIT_CNT_W  = bit_cnt_width(DATA_WIDTH)
) (
    input logic               clk,
    input logic               rst_n,
    spi_trng_master_if.master bus
);
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic                  start_q, start_d;
    logic                  ss_n_q, ss_n_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic                  tx_finish_q, tx_finish_d;

    logic accept;
    logic in_frame;
    logic phase_done;
    logic restart;

    assign accept   = bus.tx_valid && (state_q == IDLE);
    assign in_frame = state_q inside {SETUP, SCLK_HI, SCLK_LO, HOLD};
    assign restart  = (state_d != state_q);

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (in_frame),
        .restart_i    (restart),
        .phase_done_o (phase_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = START;
            START:   state_d = SETUP;
            SETUP:   if (phase_done) state_d = SCLK_HI;
            SCLK_HI: if (phase_done) begin
                state_d = (bit_cnt_q == BIT_CNT_W'(DATA_WIDTH)) ? HOLD : SCLK_LO;
            end
            SCLK_LO: if (phase_done) state_d = SCLK_HI;
            HOLD:    if (phase_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shift only on HI->LO, so the last bit never triggers a trailing data change.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            shift_d = bus.tx_data;
        end else if (state_q == SCLK_HI && state_d == SCLK_LO) begin
            shift_d = shift_q >> 1;
        end
        if (state_q == IDLE) begin
            bit_cnt_d = '0;
        end else if (state_d == SCLK_HI && state_q != SCLK_HI) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        start_d     = (state_q == START);
        ss_n_d      = !in_frame;
        sclk_d      = (state_q == SCLK_HI);
        tx_finish_d = (state_q == DONE);
        mosi_d      = mosi_q;
        if (state_q == SETUP || state_q == SCLK_LO) begin
            mosi_d = shift_q[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q     <= 1'b0;
            ss_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            tx_finish_q <= 1'b0;
        end else begin
            start_q     <= start_d;
            ss_n_q      <= ss_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            tx_finish_q <= tx_finish_d;
        end
    end

    assign bus.tx_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.start     = start_q;
    assign bus.ss_n      = ss_n_q;
    assign bus.sclk      = sclk_q;
    assign bus.mosi      = mosi_q;
    assign bus.tx_finish = tx_finish_q;

endmodule

// File: tb/tb_spi_trng_master.sv
// Directed bench for spi_trng_master: a D=4 instance with an attached receiver
// model, plus a D=2 instance for the fast-divider timing checks.
module tb_spi_trng_master;
    import spi_trng_pkg::*;

    localparam int DW = 96;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    spi_trng_master_if #(.DATA_WIDTH(DW)) bus  ();
    spi_trng_master_if #(.DATA_WIDTH(DW)) bus2 ();

    spi_trng_master #(.DATA_WIDTH(DW), .CLK_DIV(4), .BIT_CNT_W(7)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    spi_trng_master #(.DATA_WIDTH(DW), .CLK_DIV(2), .BIT_CNT_W(7)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    // Receiver model / monitor for the D=4 instance
    int acc_q[$];
    logic [DW-1:0] fin_words[$];
    int fin_rises[$];
    int fin_cnt = 0, fin_cyc = 0, start_cyc = 0;
    int rises = 0, ones = 0, one_at = 0, first_rise = 0, last_rise = 0;
    int ss_first = -1, ss_last = 0, mosi_chg = -100, viol = 0;
    logic [DW-1:0] rx = '0;
    logic sclk_p = 1'b0, mosi_p = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tx_valid && bus.tx_ready) acc_q.push_back(cyc + 1);
            if (bus.start) begin
                start_cyc = cyc; rises = 0; ones = 0; one_at = 0; rx = '0; ss_first = -1;
            end
            if (!bus.ss_n) begin
                if (ss_first < 0) ss_first = cyc;
                ss_last = cyc;
            end
            if (bus.mosi !== mosi_p) begin
                mosi_chg = cyc;
                if (bus.sclk) viol++;
            end
            if (bus.sclk && !sclk_p) begin
                rises++;
                if (rises == 1) first_rise = cyc;
                last_rise = cyc;
                rx = {bus.mosi, rx[DW-1:1]};
                if (bus.mosi) begin ones++; if (one_at == 0) one_at = rises; end
                if (cyc - mosi_chg < 4) viol++;
            end
            if (bus.tx_finish) begin
                fin_cnt++; fin_cyc = cyc;
                fin_words.push_back(rx); fin_rises.push_back(rises);
            end
        end
        mosi_p = bus.mosi;
        sclk_p = bus.sclk;
    end

    // Monitor for the D=2 instance
    int acc2_q[$];
    int fin2_cyc[$];
    logic [DW-1:0] fin2_words[$];
    int rises2 = 0, mosi2_chg = -100, viol2 = 0;
    logic [DW-1:0] rx2 = '0;
    logic sclk2_p = 1'b0, mosi2_p = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus2.tx_valid && bus2.tx_ready) acc2_q.push_back(cyc + 1);
            if (bus2.start) begin rises2 = 0; rx2 = '0; end
            if (bus2.mosi !== mosi2_p) begin
                mosi2_chg = cyc;
                if (bus2.sclk) viol2++;
            end
            if (bus2.sclk && !sclk2_p) begin
                rises2++;
                rx2 = {bus2.mosi, rx2[DW-1:1]};
                if (cyc - mosi2_chg < 2) viol2++;
            end
            if (bus2.tx_finish) begin
                fin2_cyc.push_back(cyc);
                fin2_words.push_back(rx2);
            end
        end
        mosi2_p = bus2.mosi;
        sclk2_p = bus2.sclk;
    end

    task automatic send(input logic [DW-1:0] w, input bit keep_valid);
        int n0;
        @(posedge clk); #1;
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        n0 = acc_q.size();
        for (int i = 0; i < 2000 && acc_q.size() == n0; i++) @(negedge clk);
        checks++;
        if (acc_q.size() == n0) begin
            errors++;
            $display("FAIL accept_timeout: got no accept, expected accept within 2000 cycles");
        end
        @(posedge clk); #1;
        if (!keep_valid) bus.tx_valid = 1'b0;
    endtask

    task automatic wait_fin(input int n);
        int i;
        for (i = 0; i < 2000 && fin_cnt < n; i++) @(negedge clk);
        #1;
        checks++;
        if (fin_cnt < n) begin
            errors++;
            $display("FAIL finish_timeout: got %0d finishes, expected %0d", fin_cnt, n);
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks += 7;
        if (bus.ss_n !== 1'b1)      begin errors++; $display("FAIL rst_ss_n: got %b expected 1", bus.ss_n); end
        if (bus.sclk !== 1'b0)      begin errors++; $display("FAIL rst_sclk: got %b expected 0", bus.sclk); end
        if (bus.mosi !== 1'b0)      begin errors++; $display("FAIL rst_mosi: got %b expected 0", bus.mosi); end
        if (bus.start !== 1'b0)     begin errors++; $display("FAIL rst_start: got %b expected 0", bus.start); end
        if (bus.tx_finish !== 1'b0) begin errors++; $display("FAIL rst_tx_finish: got %b expected 0", bus.tx_finish); end
        if (bus.tx_ready !== 1'b1)  begin errors++; $display("FAIL rst_tx_ready: got %b expected 1", bus.tx_ready); end
        if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        #20 rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_single();
        logic [DW-1:0] w;
        int t0, base;
        w = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
        acc_q.delete(); fin_words.delete(); fin_rises.delete();
        base = fin_cnt;
        send(w, 1'b0);
        wait_fin(base + 1);
        t0 = acc_q[0];
        checks += 9;
        if (fin_rises[0] !== 96)      begin errors++; $display("FAIL single_rises: got %0d expected 96", fin_rises[0]); end
        if (fin_words[0] !== w)       begin errors++; $display("FAIL single_data: got %h expected %h", fin_words[0], w); end
        if (start_cyc - t0 !== 1)     begin errors++; $display("FAIL single_start_t: got %0d expected 1", start_cyc - t0); end
        if (first_rise - t0 !== 6)    begin errors++; $display("FAIL single_first_rise: got %0d expected 6", first_rise - t0); end
        if (last_rise - t0 !== 766)   begin errors++; $display("FAIL single_last_rise: got %0d expected 766", last_rise - t0); end
        if (fin_cyc - t0 !== 774)     begin errors++; $display("FAIL single_finish_t: got %0d expected 774", fin_cyc - t0); end
        if (ss_first - t0 !== 2)      begin errors++; $display("FAIL single_ss_low_first: got %0d expected 2", ss_first - t0); end
        if (ss_last - t0 !== 773)     begin errors++; $display("FAIL single_ss_low_last: got %0d expected 773", ss_last - t0); end
        if (viol !== 0)               begin errors++; $display("FAIL single_mosi_timing: got %0d violations expected 0", viol); end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] wa, wb;
        int base;
        wa = {24{4'hA}};
        wb = {24{4'h5}};
        acc_q.delete(); fin_words.delete(); fin_rises.delete();
        base = fin_cnt;
        send(wa, 1'b1);
        send(wb, 1'b0);
        wait_fin(base + 2);
        checks += 5;
        if (acc_q[1] - acc_q[0] !== 775)  begin errors++; $display("FAIL b2b_accept_t: got %0d expected 775", acc_q[1] - acc_q[0]); end
        if (ss_first - acc_q[0] !== 777)  begin errors++; $display("FAIL b2b_ss_gap: got %0d expected 777", ss_first - acc_q[0]); end
        if (fin_words[0] !== wa)          begin errors++; $display("FAIL b2b_word0: got %h expected %h", fin_words[0], wa); end
        if (fin_words[1] !== wb)          begin errors++; $display("FAIL b2b_word1: got %h expected %h", fin_words[1], wb); end
        if (fin_rises[1] !== 96)          begin errors++; $display("FAIL b2b_rises1: got %0d expected 96", fin_rises[1]); end
    endtask

    task automatic test_valid_ignored();
        int base, ready_hi;
        acc_q.delete(); fin_words.delete(); fin_rises.delete();
        base = fin_cnt;
        ready_hi = 0;
        rises = 0;
        send('0, 1'b0);
        for (int i = 0; i < 2000 && rises < 96; i++) begin
            @(posedge clk); #1;
            bus.tx_valid = ~bus.tx_valid;
            bus.tx_data  = '1;
            if (bus.tx_ready) ready_hi++;
        end
        bus.tx_valid = 1'b0;
        wait_fin(base + 1);
        checks += 4;
        if (ready_hi !== 0)        begin errors++; $display("FAIL ign_ready: got %0d ready cycles expected 0", ready_hi); end
        if (ones !== 0)            begin errors++; $display("FAIL ign_mosi: got %0d ones expected 0", ones); end
        if (fin_words[0] !== '0)   begin errors++; $display("FAIL ign_data: got %h expected 0", fin_words[0]); end
        if (acc_q.size() !== 1)    begin errors++; $display("FAIL ign_accepts: got %0d expected 1", acc_q.size()); end
    endtask

    task automatic test_abort();
        int base;
        logic [DW-1:0] one_w;
        one_w = 96'h1;
        acc_q.delete(); fin_words.delete(); fin_rises.delete();
        rises = 0;
        send('1, 1'b0);
        for (int i = 0; i < 2000 && rises < 40; i++) @(negedge clk);
        base = fin_cnt;
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.ss_n !== 1'b1)     begin errors++; $display("FAIL abort_ss_n: got %b expected 1", bus.ss_n); end
        if (bus.sclk !== 1'b0)     begin errors++; $display("FAIL abort_sclk: got %b expected 0", bus.sclk); end
        if (bus.mosi !== 1'b0)     begin errors++; $display("FAIL abort_mosi: got %b expected 0", bus.mosi); end
        if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL abort_tx_ready: got %b expected 1", bus.tx_ready); end
        #27 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (fin_cnt !== base) begin errors++; $display("FAIL abort_no_finish: got %0d expected %0d", fin_cnt, base); end
        send(one_w, 1'b0);
        wait_fin(base + 1);
        checks += 3;
        if (fin_words[0] !== one_w) begin errors++; $display("FAIL abort_new_data: got %h expected %h", fin_words[0], one_w); end
        if (ones !== 1)             begin errors++; $display("FAIL abort_ones: got %0d expected 1", ones); end
        if (one_at !== 1)           begin errors++; $display("FAIL abort_one_at: got rise %0d expected 1", one_at); end
    endtask

    task automatic test_clkdiv2();
        logic [DW-1:0] w;
        int n0;
        for (int k = 0; k < 3; k++) begin
            w = {$urandom(), $urandom(), $urandom()};
            acc2_q.delete(); fin2_cyc.delete(); fin2_words.delete();
            @(posedge clk); #1;
            bus2.tx_data  = w;
            bus2.tx_valid = 1'b1;
            for (int i = 0; i < 100 && acc2_q.size() == 0; i++) @(negedge clk);
            @(posedge clk); #1;
            bus2.tx_valid = 1'b0;
            for (int i = 0; i < 1000 && fin2_cyc.size() == 0; i++) @(negedge clk);
            #1;
            checks++;
            if (acc2_q.size() == 0 || fin2_cyc.size() == 0) begin
                errors++;
                $display("FAIL div2_timeout: got accepts=%0d finishes=%0d expected 1 each", acc2_q.size(), fin2_cyc.size());
            end else begin
                checks += 3;
                if (fin2_cyc[0] - acc2_q[0] !== 388) begin errors++; $display("FAIL div2_latency: got %0d expected 388", fin2_cyc[0] - acc2_q[0]); end
                if (fin2_words[0] !== w)             begin errors++; $display("FAIL div2_data: got %h expected %h", fin2_words[0], w); end
                if (rises2 !== 96)                   begin errors++; $display("FAIL div2_rises: got %0d expected 96", rises2); end
            end
        end
        checks++;
        if (viol2 !== 0) begin errors++; $display("FAIL div2_mosi_timing: got %0d violations expected 0", viol2); end
    endtask

    initial begin
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        bus2.tx_valid = 1'b0;
        bus2.tx_data  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_valid_ignored();
        test_abort();
        test_clkdiv2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
